// File: rtl/controlador_funcion_conf_if.sv
// -----------------------------------------------------------------------------
// controlador_funcion_conf_if
//
// Purpose:
//   Bundles the configuration-mode signals that the function controller drives
//   toward the register chip-select decoder and the RTC write sequencer.
//
// Signals:
//   funcion_conf       [2:0] mode code: 000 IDLE, 001 HORA, 010 FECHA, 100 TIMER
//   flag_mostrar_count       countdown running / displayed
//   config_activa            high whenever funcion_conf != 000
//   pulso_escritura          one-cycle commit strobe on a confirmed exit
//   modo_escrito       [2:0] code of the committed mode while pulso_escritura=1
//
// Modports:
//   master  the controller (drives every signal)
//   slave   the decoder / write sequencer (reads every signal)
// -----------------------------------------------------------------------------
interface controlador_funcion_conf_if;

    logic [2:0] funcion_conf;
    logic       flag_mostrar_count;
    logic       config_activa;
    logic       pulso_escritura;
    logic [2:0] modo_escrito;

    modport master (
        output funcion_conf,
        output flag_mostrar_count,
        output config_activa,
        output pulso_escritura,
        output modo_escrito
    );

    modport slave (
        input funcion_conf,
        input flag_mostrar_count,
        input config_activa,
        input pulso_escritura,
        input modo_escrito
    );

endinterface

// File: rtl/controlador_funcion_conf.sv
// -----------------------------------------------------------------------------
// controlador_funcion_conf
//
// Purpose:
//   Turns debounced button pulses into a one-hot configuration mode, abandons
//   an open configuration after TIMEOUT_CICLOS cycles without button activity,
//   and emits a one-cycle write-commit strobe when the user confirms an edit.
//   Also keeps the "countdown shown" flag that the decoder uses to keep the
//   timer chip-selects asserted.
//
// Parameters:
//   TIMEOUT_CICLOS  cycles of inactivity before a configuration is abandoned
//                   (minimum 2)
//   CNT_W           inactivity counter width, 2**CNT_W > TIMEOUT_CICLOS
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   btn_hora            pulse: request time-of-day configuration
//   btn_fecha           pulse: request date configuration
//   btn_timer           pulse: request countdown-timer configuration
//   btn_salir           pulse: confirm and leave the current configuration
//   btn_cancelar_timer  pulse: stop the running countdown display
//   fin_timer           pulse: countdown reached zero
//   bus                 master side of controlador_funcion_conf_if
// -----------------------------------------------------------------------------
module controlador_funcion_conf #(
    parameter int unsigned TIMEOUT_CICLOS = 500000000,
    parameter int unsigned CNT_W          = 29
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          btn_hora,
    input  logic                          btn_fecha,
    input  logic                          btn_timer,
    input  logic                          btn_salir,
    input  logic                          btn_cancelar_timer,
    input  logic                          fin_timer,
    controlador_funcion_conf_if.master    bus
);

    // State encoding doubles as the funcion_conf output code.
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        HORA  = 3'b001,
        FECHA = 3'b010,
        TIMER = 3'b100
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(TIMEOUT_CICLOS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             config_q, config_d;
    logic             pulso_q, pulso_d;
    logic [2:0]       modo_q, modo_d;
    logic             hay_boton;

    // Next-state logic. Outside IDLE, btn_salir is checked first so a
    // confirmed exit beats both simultaneous mode buttons and a timeout that
    // would expire on the same cycle. Any button pulse while editing counts
    // as activity and restarts the inactivity window.
    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        pulso_d   = 1'b0;
        modo_d    = 3'b000;
        hay_boton = btn_hora | btn_fecha | btn_timer | btn_salir | btn_cancelar_timer;

        if (estado_q == IDLE) begin
            cnt_d = '0;
            if (btn_hora) begin
                estado_d = HORA;
            end else if (btn_fecha) begin
                estado_d = FECHA;
            end else if (btn_timer) begin
                estado_d = TIMER;
            end
        end else if (btn_salir) begin
            estado_d = IDLE;
            cnt_d    = '0;
            pulso_d  = 1'b1;
            modo_d   = estado_q;
        end else if (hay_boton) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_FIN) begin
            estado_d = IDLE;
            cnt_d    = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Clear first, then set, so a confirmed TIMER exit wins over a
        // simultaneous fin_timer or cancel.
        if (btn_cancelar_timer || fin_timer) begin
            flag_d = 1'b0;
        end
        if ((estado_q == TIMER) && btn_salir) begin
            flag_d = 1'b1;
        end

        // Taken from the next state so config_activa lines up with
        // funcion_conf on the same edge.
        config_d = (estado_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            config_q <= 1'b0;
            pulso_q  <= 1'b0;
            modo_q   <= 3'b000;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            config_q <= config_d;
            pulso_q  <= pulso_d;
            modo_q   <= modo_d;
        end
    end

    assign bus.funcion_conf       = estado_q;
    assign bus.flag_mostrar_count = flag_q;
    assign bus.config_activa      = config_q;
    assign bus.pulso_escritura    = pulso_q;
    assign bus.modo_escrito       = modo_q;

endmodule
